// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-outstanding data-memory responder for the RV32I load/store port.
//   Takes one request over a valid/ready handshake, waits a fixed number of
//   cycles, then commits the access and presents the result until the
//   initiator takes it.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_we                    1 = store, 0 = load
//   req_addr                  byte address
//   req_wdata                 store data, LSB-aligned
//   req_funct3                RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata                 extended load data (0 for stores and errors)
//   rsp_err                   misaligned, out of range or illegal funct3
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) * 34'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    f3_q;
    logic          commit;

    logic [31:0]   mem [DEPTH_WORDS];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // Every request spends one cycle in WAIT even with WAIT_STATES=0: that
    // cycle decodes the latched request, so the commit (on the edge into
    // RESP) lands WAIT_STATES+1 edges after the accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        commit    = (state == WAIT) && (cnt == '0);
    end

    // ---------------- request latch / wait counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE && req_valid) begin
            cnt <= CW'(WAIT_STATES);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Payload is only meaningful between accept and commit; no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
        end
    end

    // ---------------- decode of latched request ----------------
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          oor, misal, bad_f3, err;
    logic [31:0]   rword, ld, wd;
    logic [15:0]   rsh;
    logic [3:0]    be;

    always_comb begin
        // Subtraction wraps for addr < BASE_ADDR, which the range check catches.
        off    = addr_q - BASE_ADDR;
        idx    = off[AW+1:2];
        oor    = {2'b00, off} >= LIMIT;
        misal  = (f3_q[1:0] == 2'd1 && addr_q[0]) ||
                 (f3_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0);
        bad_f3 = we_q ? (f3_q > 3'd2) : (f3_q[1:0] == 2'd3 || f3_q[2:1] == 2'b11);
        err    = oor || misal || bad_f3;

        rword  = mem[idx];
        rsh    = 16'(rword >> {addr_q[1:0], 3'b000});

        ld = '0;
        case (f3_q)
            3'd0:    ld = {{24{rsh[7]}}, rsh[7:0]};
            3'd1:    ld = {{16{rsh[15]}}, rsh[15:0]};
            3'd2:    ld = rword;
            3'd4:    ld = {24'b0, rsh[7:0]};
            3'd5:    ld = {16'b0, rsh[15:0]};
            default: ld = '0;
        endcase

        wd = wdata_q << {addr_q[1:0], 3'b000};
        be = '0;
        case (f3_q[1:0])
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = '0;
        endcase
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // ---------------- response registers ----------------
    // Loaded only on the commit edge, so they hold through any backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_err   <= err;
            rsp_rdata <= (err || we_q) ? 32'h0 : ld;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: WAIT_STATES=2, instance B: WAIT_STATES=0
    logic        a_req_valid = 0, a_req_ready, a_req_we = 0, a_rsp_valid, a_rsp_ready = 1, a_rsp_err;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_rsp_rdata;
    logic [2:0]  a_req_funct3 = 0;
    logic        b_req_valid = 0, b_req_ready, b_req_we = 0, b_rsp_valid, b_rsp_ready = 1, b_rsp_err;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_rsp_rdata;
    logic [2:0]  b_req_funct3 = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_funct3(a_req_funct3),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_funct3(b_req_funct3),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- monitors ----------------
    logic pva = 0, pvb = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) pva = 0;
        else begin
            if (a_rsp_valid && !pva) begin
                if (qa.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
                else                chk("a_latency", 32'(cyc - qa[0].acc), 32'd3);
            end
            if (a_rsp_valid && a_rsp_ready && qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_rdata", a_rsp_rdata, e.rdata);
                chk("a_err", {31'b0, a_rsp_err}, {31'b0, e.err});
            end
            pva = a_rsp_valid;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) pvb = 0;
        else begin
            if (b_rsp_valid && !pvb) begin
                if (qb.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
                else                chk("b_latency", 32'(cyc - qb[0].acc), 32'd1);
            end
            if (b_rsp_valid && b_rsp_ready && qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_rdata", b_rsp_rdata, e.rdata);
                chk("b_err", {31'b0, b_rsp_err}, {31'b0, e.err});
            end
            pvb = b_rsp_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic req(input bit b, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] er, input logic ee, input bit push);
        int n = 0;
        if (b) begin
            b_req_valid = 1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_funct3 = f3;
        end else begin
            a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_funct3 = f3;
        end
        @(negedge clk);
        while (!(b ? b_req_ready : a_req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("req_ready_timeout", 32'd0, 32'd1);
        if (push) begin
            if (b) qb.push_back('{er, ee, cyc + 1});
            else   qa.push_back('{er, ee, cyc + 1});
        end
        @(posedge clk);
        #1;
        // request inputs may change freely after accept
        if (b) begin
            b_req_valid = 0; b_req_we = 1; b_req_addr = $urandom; b_req_wdata = $urandom; b_req_funct3 = 3'd2;
        end else begin
            a_req_valid = 0; a_req_we = 1; a_req_addr = $urandom; a_req_wdata = $urandom; a_req_funct3 = 3'd2;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic tx(input bit b, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee);
        req(b, we, addr, wd, f3, er, ee, 1'b1);
        drain();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, a_rsp_err}, 32'd0);
        chk("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // word store/load
        tx(0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0);
        tx(0, 0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0);
        // byte store and byte loads
        tx(0, 1, 32'h11, 32'h0000_0055, 3'd0, 32'h0, 0);
        tx(0, 0, 32'h11, 32'h0, 3'd0, 32'h0000_0055, 0);
        tx(0, 0, 32'h13, 32'h0, 3'd4, 32'h0000_00DE, 0);
        tx(0, 0, 32'h13, 32'h0, 3'd0, 32'hFFFF_FFDE, 0);
        tx(0, 0, 32'h10, 32'h0, 3'd2, 32'hDEAD_55EF, 0);
        // halfword store and loads
        tx(0, 1, 32'h20, 32'h0, 3'd2, 32'h0, 0);
        tx(0, 1, 32'h22, 32'hFFFF_8001, 3'd1, 32'h0, 0);
        tx(0, 0, 32'h22, 32'h0, 3'd1, 32'hFFFF_8001, 0);
        tx(0, 0, 32'h22, 32'h0, 3'd5, 32'h0000_8001, 0);
        tx(0, 0, 32'h20, 32'h0, 3'd2, 32'h8001_0000, 0);
        // errors
        tx(0, 0, 32'h13, 32'h0, 3'd2, 32'h0, 1);
        tx(0, 1, 32'h0, 32'h0BAD_F00D, 3'd2, 32'h0, 0);
        tx(0, 1, 32'h1000, 32'h1111_1111, 3'd2, 32'h0, 1);
        tx(0, 0, 32'h0, 32'h0, 3'd2, 32'h0BAD_F00D, 0);
        tx(0, 0, 32'h10, 32'h0, 3'd3, 32'h0, 1);
        tx(0, 0, 32'h10, 32'h0, 3'd6, 32'h0, 1);
        tx(0, 1, 32'h10, 32'h0, 3'd3, 32'h0, 1);
        tx(0, 0, 32'h21, 32'h0, 3'd1, 32'h0, 1);
        tx(0, 1, 32'h21, 32'hFFFF_FFFF, 3'd1, 32'h0, 1);
        tx(0, 0, 32'h20, 32'h0, 3'd2, 32'h8001_0000, 0);
        tx(0, 0, 32'hFFFF_FFFC, 32'h0, 3'd2, 32'h0, 1);

        // backpressure: response held 5 cycles, competing request ignored
        a_rsp_ready = 0;
        req(0, 0, 32'h10, 32'h0, 3'd2, 32'hDEAD_55EF, 0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!a_rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("bp_valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", a_rsp_rdata, 32'hDEAD_55EF);
            chk("bp_req_ready", {31'b0, a_req_ready}, 32'd0);
            @(posedge clk);
            #1;
            a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h10; a_req_wdata = 32'h0; a_req_funct3 = 3'd2;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_req_valid = 0;
        a_rsp_ready = 1;
        drain();
        tx(0, 0, 32'h10, 32'h0, 3'd2, 32'hDEAD_55EF, 0);

        // reset during WAIT drops the store
        tx(0, 1, 32'h30, 32'hCAFE_F00D, 3'd2, 32'h0, 0);
        tx(0, 0, 32'h30, 32'h0, 3'd2, 32'hCAFE_F00D, 0);
        req(0, 1, 32'h30, 32'h1234_5678, 3'd2, 32'h0, 0, 1'b0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("wrst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("wrst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("wrst_rsp_err", {31'b0, a_rsp_err}, 32'd0);
        chk("wrst_req_ready", {31'b0, a_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        tx(0, 0, 32'h30, 32'h0, 3'd2, 32'hCAFE_F00D, 0);

        // zero wait states
        tx(1, 1, 32'h40, 32'hA5A5_5A5A, 3'd2, 32'h0, 0);
        tx(1, 0, 32'h40, 32'h0, 3'd2, 32'hA5A5_5A5A, 0);
        tx(1, 0, 32'h42, 32'h0, 3'd1, 32'h0000_A5A5 | 32'hFFFF_0000, 0);
        tx(1, 0, 32'h41, 32'h0, 3'd5, 32'h0, 1);
        tx(1, 0, 32'h40, 32'h0, 3'd4, 32'h0000_005A, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
